// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage for the 8-bit MIPS-style core.
//
// Owns the program counter. Issues word-addressed reads to an instruction SRAM
// whose read data comes back exactly one cycle after the request. Each returned
// word is buffered, together with its PC, in a DEPTH-entry prefetch FIFO. The
// FIFO head is offered to decode over a valid/ready handshake.
//
// Handshake (decode side): instr_valid/instr/instr_pc describe the FIFO head.
// A transfer happens on a rising edge where instr_valid && instr_ready. While
// instr_valid is high and instr_ready is low, instr and instr_pc hold stable.
// instr_valid never drops without a transfer, except on redirect or reset.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   imem_req, imem_addr   read strobe and word address to the instruction SRAM
//   imem_rdata            SRAM read data, valid one cycle after imem_req
//   redirect_valid/_addr  taken branch/jump; flushes the FIFO and any in-flight read
//   instr_valid/instr/instr_pc, instr_ready   decode-side handshake
//   perf_stall_cnt, perf_flush_cnt            only present with FETCH_PERF_EN
//
// Optional build macro FETCH_PERF_EN adds two saturating 16-bit counters:
//   perf_stall_cnt counts cycles where the head is valid but decode is not ready.
//   perf_flush_cnt counts redirect cycles.

module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage is deliberately not reset; count_q alone says what is live.
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic              pop;
  logic              push;
  logic [CNT_W:0]    occupancy;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // A response is dropped if a redirect arrives in the same cycle.
  assign push        = inflight_q & ~redirect_valid;

  // Credit check: entries that will remain after this cycle's pop, plus the
  // response still on its way back. Issuing only while this is below DEPTH
  // guarantees that every response finds a free slot.
  assign occupancy = {1'b0, count_q} - {{CNT_W{1'b0}}, pop} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req  = ~reset & ~redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // Gate the head with instr_valid so the outputs read zero when the FIFO is
  // empty, even though the storage itself keeps stale contents.
  assign instr    = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc = instr_valid ? pc_mem_q[rd_ptr_q]    : '0;

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;

    if (redirect_valid) begin
      // Flush everything buffered and in flight; fetch restarts at the target
      // next cycle.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      fetch_pc_d = redirect_addr;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      inflight_d = imem_req;
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (instr_valid && !instr_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (redirect_valid && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit - self-checking bench for fetch_unit.
// DUT a uses RESET_PC=0 and carries the main scenarios. DUT b uses RESET_PC=8'hFE
// and checks PC wrap-around. The SRAM model returns 32'h1000_0000 + addr one
// cycle after each request. Inputs are driven 1 time unit after the rising edge;
// outputs are sampled on the falling edge.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;

  logic        reset_b;
  logic        imem_req_b;
  logic [7:0]  imem_addr_b;
  logic [31:0] imem_rdata_b;
  logic        instr_valid_b;
  logic [31:0] instr_b;
  logic [7:0]  instr_pc_b;
  logic        instr_ready_b;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
  logic [15:0] perf_stall_cnt_b, perf_flush_cnt_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  int req_seen = 0;
  int pops_seen = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  model_pc = 8'h00;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and SRAM models ----------------
  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4), .RESET_PC(8'hFE)) dut_b (
    .clk(clk), .reset(reset_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .redirect_valid(1'b0), .redirect_addr(8'h00),
    .instr_valid(instr_valid_b), .instr(instr_b), .instr_pc(instr_pc_b),
    .instr_ready(instr_ready_b)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt_b), .perf_flush_cnt(perf_flush_cnt_b)
`endif
  );

  always @(posedge clk) begin
    if (imem_req)   imem_rdata   <= 32'h1000_0000 + {24'h0, imem_addr};
    if (imem_req_b) imem_rdata_b <= 32'h1000_0000 + {24'h0, imem_addr_b};
  end

  // ---------------- scoreboard ----------------
  // Called at the falling edge. Checks any pop against the queue head, then
  // applies a flush (reset or redirect), then records a new request.
  task automatic sb_sample();
    logic [39:0] e;
    if (instr_valid && instr_ready) begin
      vectors++;
      pops_seen++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_pop_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          miscompares++;
          $display("FAIL sb_pop: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc, instr, e[39:32], e[31:0]);
        end
      end
    end
    if (reset || redirect_valid) begin
      exp_q.delete();
      model_pc = reset ? 8'h00 : redirect_addr;
    end
    if (imem_req) begin
      vectors++;
      req_seen++;
      if (imem_addr !== model_pc) begin
        miscompares++;
        $display("FAIL sb_req_addr: got %h, required %h", imem_addr, model_pc);
      end
      exp_q.push_back({model_pc, 32'h1000_0000 + {24'h0, model_pc}});
      model_pc = model_pc + 8'd1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h00; instr_ready = 1'b0;
    reset_b = 1'b1; instr_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({imem_req, instr_valid, instr, instr_pc} !== 42'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b valid=%b instr=%h pc=%h, required all zero",
               imem_req, instr_valid, instr, instr_pc);
    end
    sb_sample();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 8'(k)) begin
        miscompares++;
        $display("FAIL stream_req c%0d: got req=%b addr=%h, required req=1 addr=%h", k, imem_req, imem_addr, 8'(k));
      end
      vectors++;
      if (instr_valid !== (k >= 2)) begin
        miscompares++;
        $display("FAIL stream_valid c%0d: got %b, required %b", k, instr_valid, (k >= 2));
      end
      sb_sample();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    do_reset();
    req_seen = 0;
    repeat (8) step();
    vectors++;
    if (req_seen != 4) begin
      miscompares++;
      $display("FAIL stall_req_count: got %0d, required 4", req_seen);
    end
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
      miscompares++;
      $display("FAIL stall_hold: got req=%b valid=%b pc=%h, required req=0 valid=1 pc=00",
               imem_req, instr_valid, instr_pc);
    end
    sb_sample();
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    pops_seen = 0;
    repeat (12) step();
    vectors++;
    if (pops_seen != 12) begin
      miscompares++;
      $display("FAIL stall_release_pops: got %0d, required 12", pops_seen);
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1;
    do_reset();
    repeat (6) step();
    redirect_valid = 1'b1; redirect_addr = 8'h40;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_req_r: got %b, required 0", imem_req);
    end
    sb_sample();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (c == 1 && (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0)) begin
        miscompares++;
        $display("FAIL redirect_r1: got req=%b addr=%h valid=%b, required req=1 addr=40 valid=0",
                 imem_req, imem_addr, instr_valid);
      end
      if (c == 2 && instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redirect_r2: got valid=%b, required 0", instr_valid);
      end
      if (c == 3 && (instr_valid !== 1'b1 || instr_pc !== 8'h40)) begin
        miscompares++;
        $display("FAIL redirect_r3: got valid=%b pc=%h, required valid=1 pc=40", instr_valid, instr_pc);
      end
      sb_sample();
      @(posedge clk);
      #1;
    end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_addr = 8'h40;
    step();
    redirect_addr = 8'h80;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_req_r1: got %b, required 0", imem_req);
    end
    sb_sample();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h80) begin
      miscompares++;
      $display("FAIL b2b_addr: got req=%b addr=%h, required req=1 addr=80", imem_req, imem_addr);
    end
    sb_sample();
    @(posedge clk);
    #1;
    step();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h80) begin
      miscompares++;
      $display("FAIL b2b_first: got valid=%b pc=%h, required valid=1 pc=80", instr_valid, instr_pc);
    end
    sb_sample();
    @(posedge clk);
    #1;
    repeat (5) step();
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b0;
    do_reset();
    repeat (4) step();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_assert: got req=%b valid=%b, required req=0 valid=1", imem_req, instr_valid);
    end
    sb_sample();
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 8'h00 || instr !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_next: got req=%b valid=%b pc=%h instr=%h, required all zero",
               imem_req, instr_valid, instr_pc, instr);
    end
    sb_sample();
    @(posedge clk);
    #1;
    reset = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_restart: got req=%b addr=%h, required req=1 addr=00", imem_req, imem_addr);
    end
    sb_sample();
    @(posedge clk);
    #1;
    repeat (6) step();
  endtask

  task automatic test_wrap();
    int got;
    logic [7:0] exp_pc;
    got = 0;
    exp_pc = 8'hFE;
    instr_ready_b = 1'b1;
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (instr_valid_b) begin
        vectors++;
        if (instr_pc_b !== exp_pc || instr_b !== 32'h1000_0000 + {24'h0, exp_pc}) begin
          miscompares++;
          $display("FAIL wrap_seq: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc_b, instr_b, exp_pc, 32'h1000_0000 + {24'h0, exp_pc});
        end
        exp_pc = exp_pc + 8'd1;
        got++;
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d instructions, required 4", got);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    instr_ready = 1'b1;
    do_reset();
    @(negedge clk);
    vectors++;
    if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL perf_reset: got stall=%0d flush=%0d, required 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    sb_sample();
    @(posedge clk);
    #1;
    repeat (3) step();
    instr_ready = 1'b0;
    repeat (5) step();
    instr_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_addr = 8'h10;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_addr = 8'h20;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    vectors++;
    if (perf_stall_cnt !== 16'd5 || perf_flush_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d, required 5/2", perf_stall_cnt, perf_flush_cnt);
    end
    sb_sample();
    @(posedge clk);
    #1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
